// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces active-low push-button lines.
// Each key has a 2-flop synchroniser and a counter. A new level is accepted
// only after it has persisted for DEBOUNCE_CYCLES consecutive clocks.
// One-cycle press/release strobes are raised in the cycle key_stable changes.
// Optional macro KEY_IRQ_EN: adds sticky per-key press flags (key_pending),
// cleared by irq_ack, and an interrupt output irq = |key_pending.
module key_debounce #(
  parameter int unsigned N_KEYS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_stable,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  input  logic              irq_ack,
  output logic [N_KEYS-1:0] key_pending,
  output logic              irq
);

  // Counter value that completes the debounce window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;

  // Two-flop synchroniser; idle level is released (1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : gKey
    logic [CNT_W-1:0] cnt;
    logic             stableQ;
    logic             pressQ;
    logic             releaseQ;

    // Per-key debounce: count while sync2 differs, accept at the last count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt      <= '0;
        stableQ  <= 1'b1;
        pressQ   <= 1'b0;
        releaseQ <= 1'b0;
      end else begin
        pressQ   <= 1'b0;
        releaseQ <= 1'b0;
        if (sync2[g] == stableQ) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt      <= '0;
          stableQ  <= sync2[g];
          pressQ   <= ~sync2[g];
          releaseQ <= sync2[g];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign key_stable[g]  = stableQ;
    assign key_press[g]   = pressQ;
    assign key_release[g] = releaseQ;
  end

`ifdef KEY_IRQ_EN
  // Sticky press flags; a new press wins over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_pending <= '0;
      irq         <= 1'b0;
    end else begin
      key_pending <= (key_pending & ~{N_KEYS{irq_ack}}) | key_press;
      irq         <= |key_pending;
    end
  end
`else
  // Interrupt feature absent: outputs tied off, acknowledge ignored.
  logic unusedIrqAck;
  assign unusedIrqAck = irq_ack;
  assign key_pending  = '0;
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and randomized checks of key_debounce
// (DEBOUNCE_CYCLES=4, CNT_W=3) against a sliding-window reference model.
module tb_key_debounce;

  localparam int unsigned NK = 8;
  localparam int unsigned DC = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          irq_ack = 1'b0;
  logic [NK-1:0] key_raw = 8'h00;
  logic [NK-1:0] key_stable;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_pending;
  logic          irq;

  int nCompared   = 0;
  int nMismatched = 0;

  key_debounce #(.N_KEYS(NK), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw),
    .key_stable(key_stable), .key_press(key_press), .key_release(key_release),
    .irq_ack(irq_ack), .key_pending(key_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a key flips once its last DC synchronised samples all
  // disagree with the current stable level. hist[j] = raw sampled j+1 edges ago;
  // the synchroniser delays by two edges, so the window is hist[1..DC].
  logic [NK-1:0] hist [0:DC];
  logic [NK-1:0] mStable, mPress, mRelease, mPend;
  logic          mIrq;

  always @(posedge clk or negedge reset_n) begin : model
    logic [NK-1:0] flip;
    if (!reset_n) begin
      for (int j = 0; j <= DC; j++) hist[j] <= 8'hFF;
      mStable  <= 8'hFF;
      mPress   <= 8'h00;
      mRelease <= 8'h00;
      mPend    <= 8'h00;
      mIrq     <= 1'b0;
    end else begin
      flip = 8'hFF;
      for (int j = 1; j <= DC; j++) flip = flip & (hist[j] ^ mStable);
      mStable  <= mStable ^ flip;
      mPress   <= flip & mStable;
      mRelease <= flip & ~mStable;
      hist[0]  <= key_raw;
      for (int j = 1; j <= DC; j++) hist[j] <= hist[j-1];
`ifdef KEY_IRQ_EN
      mPend <= (mPend & ~{NK{irq_ack}}) | mPress;
      mIrq  <= |mPend;
`endif
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; key_raw = 8'h00; irq_ack = 1'b0;
    repeat (3) tick;
    nCompared++; if (key_stable !== 8'hFF) begin nMismatched++; $display("FAIL reset_stable: got %h expected ff", key_stable); end
    nCompared++; if (key_press !== 8'h00) begin nMismatched++; $display("FAIL reset_press: got %h expected 00", key_press); end
    nCompared++; if (key_release !== 8'h00) begin nMismatched++; $display("FAIL reset_release: got %h expected 00", key_release); end
    nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("FAIL reset_irq: got %b expected 0", irq); end
    nCompared++; if (key_pending !== 8'h00) begin nMismatched++; $display("FAIL reset_pending: got %h expected 00", key_pending); end
    reset_n = 1'b1;
    tick;
    nCompared++; if (key_stable !== 8'hFF) begin nMismatched++; $display("FAIL reset_after_release: got %h expected ff", key_stable); end
    key_raw = 8'hFF;
    repeat (8) tick;
    nCompared++; if (key_stable !== 8'hFF) begin nMismatched++; $display("FAIL reset_settle: got %h expected ff", key_stable); end
  endtask

  task automatic test_clean_press;
    logic [NK-1:0] expP, expS;
    key_raw = 8'hFE;
    for (int j = 1; j <= 7; j++) begin
      tick;
      expP = (j == 6) ? 8'h01 : 8'h00;
      expS = (j >= 6) ? 8'hFE : 8'hFF;
      nCompared++; if (key_press !== expP) begin nMismatched++; $display("FAIL clean_press t%0d: got %h expected %h", j, key_press, expP); end
      nCompared++; if (key_stable !== expS) begin nMismatched++; $display("FAIL clean_stable t%0d: got %h expected %h", j, key_stable, expS); end
    end
    key_raw = 8'hFF;
    for (int j = 1; j <= 7; j++) begin
      tick;
      expP = (j == 6) ? 8'h01 : 8'h00;
      nCompared++; if (key_release !== expP) begin nMismatched++; $display("FAIL clean_release t%0d: got %h expected %h", j, key_release, expP); end
    end
  endtask

  task automatic test_glitch;
    logic [NK-1:0] expP, expR;
    key_raw = 8'hF7;
    for (int j = 1; j <= 10; j++) begin
      tick;
      if (j == 3) key_raw = 8'hFF;
      nCompared++; if (key_stable !== 8'hFF || key_press !== 8'h00) begin
        nMismatched++; $display("FAIL glitch_short t%0d: got stable %h press %h expected ff 00", j, key_stable, key_press);
      end
    end
    key_raw = 8'hF7;
    for (int j = 1; j <= 12; j++) begin
      tick;
      if (j == 5) key_raw = 8'hFF;
      expP = (j == 6) ? 8'h08 : 8'h00;
      expR = (j == 11) ? 8'h08 : 8'h00;
      nCompared++; if (key_press !== expP) begin nMismatched++; $display("FAIL glitch_long_press t%0d: got %h expected %h", j, key_press, expP); end
      nCompared++; if (key_release !== expR) begin nMismatched++; $display("FAIL glitch_long_release t%0d: got %h expected %h", j, key_release, expR); end
    end
  endtask

  task automatic test_bounce;
    logic [NK-1:0] expP;
    for (int t = 0; t <= 20; t++) begin
      if (t < 12) key_raw = ((t / 2) % 2 == 0) ? 8'hFE : 8'hFF;
      else key_raw = 8'hFE;
      tick;
      expP = (t == 17) ? 8'h01 : 8'h00;
      nCompared++; if (key_press !== expP || key_release !== 8'h00) begin
        nMismatched++; $display("FAIL bounce t%0d: got press %h release %h expected %h 00", t, key_press, key_release, expP);
      end
    end
    key_raw = 8'hFF;
    repeat (7) tick;
    nCompared++; if (key_stable !== 8'hFF) begin nMismatched++; $display("FAIL bounce_cleanup: got %h expected ff", key_stable); end
  endtask

  task automatic test_multi_key;
    logic [NK-1:0] expP;
    key_raw = 8'h5A;
    for (int j = 1; j <= 6; j++) begin
      tick;
      expP = (j == 6) ? 8'hA5 : 8'h00;
      nCompared++; if (key_press !== expP) begin nMismatched++; $display("FAIL multi_press t%0d: got %h expected %h", j, key_press, expP); end
    end
    nCompared++; if (key_stable !== 8'h5A) begin nMismatched++; $display("FAIL multi_stable: got %h expected 5a", key_stable); end
    key_raw = 8'hFF;
    for (int j = 1; j <= 6; j++) begin
      tick;
      expP = (j == 6) ? 8'hA5 : 8'h00;
      nCompared++; if (key_release !== expP) begin nMismatched++; $display("FAIL multi_release t%0d: got %h expected %h", j, key_release, expP); end
    end
  endtask

  task automatic test_reset_mid_count;
    logic [NK-1:0] expP;
    key_raw = 8'hFE;
    repeat (4) tick;
    reset_n = 1'b0;
    tick;
    nCompared++; if (key_stable !== 8'hFF || key_press !== 8'h00) begin
      nMismatched++; $display("FAIL midreset_abort: got stable %h press %h expected ff 00", key_stable, key_press);
    end
    reset_n = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick;
      expP = (j == 6) ? 8'h01 : 8'h00;
      nCompared++; if (key_press !== expP) begin nMismatched++; $display("FAIL midreset_press t%0d: got %h expected %h", j, key_press, expP); end
    end
    key_raw = 8'hFF;
    repeat (7) tick;
    nCompared++; if (key_stable !== 8'hFF) begin nMismatched++; $display("FAIL midreset_cleanup: got %h expected ff", key_stable); end
  endtask

`ifdef KEY_IRQ_EN
  task automatic test_irq;
    irq_ack = 1'b1; tick; irq_ack = 1'b0; tick;
    key_raw = 8'hFD;
    repeat (6) tick;
    nCompared++; if (key_press !== 8'h02) begin nMismatched++; $display("FAIL irq_press1: got %h expected 02", key_press); end
    tick;
    nCompared++; if (key_pending !== 8'h02) begin nMismatched++; $display("FAIL irq_pending1: got %h expected 02", key_pending); end
    tick;
    nCompared++; if (irq !== 1'b1) begin nMismatched++; $display("FAIL irq_raise: got %b expected 1", irq); end
    key_raw = 8'hFF;
    repeat (7) tick;
    key_raw = 8'hFB;
    repeat (6) tick;
    nCompared++; if (key_press !== 8'h04) begin nMismatched++; $display("FAIL irq_press2: got %h expected 04", key_press); end
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    nCompared++; if (key_pending !== 8'h04) begin nMismatched++; $display("FAIL irq_set_wins: got %h expected 04", key_pending); end
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
    nCompared++; if (key_pending !== 8'h00) begin nMismatched++; $display("FAIL irq_ack_clear: got %h expected 00", key_pending); end
    tick;
    nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("FAIL irq_drop: got %b expected 0", irq); end
    key_raw = 8'hFF;
    repeat (7) tick;
  endtask
`else
  task automatic test_irq;
    key_raw = 8'hFD;
    for (int j = 1; j <= 16; j++) begin
      irq_ack = (j % 3 == 0);
      if (j == 9) key_raw = 8'hFF;
      tick;
      nCompared++; if (irq !== 1'b0 || key_pending !== 8'h00) begin
        nMismatched++; $display("FAIL irq_disabled t%0d: got irq %b pending %h expected 0 00", j, irq, key_pending);
      end
    end
    irq_ack = 1'b0;
    repeat (7) tick;
  endtask
`endif

  task automatic test_random;
    for (int c = 0; c < 3000; c++) begin
      nCompared++; if (key_stable !== mStable) begin nMismatched++; $display("FAIL rand_stable c%0d: got %h expected %h", c, key_stable, mStable); end
      nCompared++; if (key_press !== mPress) begin nMismatched++; $display("FAIL rand_press c%0d: got %h expected %h", c, key_press, mPress); end
      nCompared++; if (key_release !== mRelease) begin nMismatched++; $display("FAIL rand_release c%0d: got %h expected %h", c, key_release, mRelease); end
      nCompared++; if (key_pending !== mPend || irq !== mIrq) begin
        nMismatched++; $display("FAIL rand_irq c%0d: got %h/%b expected %h/%b", c, key_pending, irq, mPend, mIrq);
      end
      if ((c / 200) % 2 == 0)
        key_raw = key_raw ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      else
        key_raw = key_raw ^ (8'($urandom) & 8'($urandom) & 8'($urandom)
                           & 8'($urandom) & 8'($urandom) & 8'($urandom));
      irq_ack = ($urandom_range(0, 7) == 0);
      tick;
    end
    irq_ack = 1'b0;
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_glitch;
    test_bounce;
    test_multi_key;
    test_reset_mid_count;
    test_irq;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
